// File: rtl/fmps_pkg.sv
// Shared constants, FSM encoding and link-slice helpers for the FMPS status gatherer.
package fmps_pkg;

  localparam int unsigned CODE_W = 2;
  localparam logic [CODE_W-1:0] ST_SUCCESS = 2'd0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VALID   = 2'd2,
    TIMEOUT = 2'd3
  } fmps_state_e;

  // Low bit of link k's slice in a flattened per-link bus of w bits per link.
  function automatic int unsigned slice_lo(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/fmps_popcount.sv
// Combinational population count of a bitmap.
module fmps_popcount #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CNT_W-1:0] count_c
);

  always_comb begin
    count_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      count_c = count_c + CNT_W'(data_i[i]);
    end
  end

endmodule

// File: rtl/fmps_gather_n.sv
// Gathers per-FA-cycle FMPS success statuses from several links into bitmaps and
// flags completion (count reached) or timeout (µs timer reached limit).
module fmps_gather_n
  import fmps_pkg::*;
#(
  parameter int unsigned NUM_LINKS   = 2,
  parameter int unsigned INDEX_WIDTH = 5,
  parameter int unsigned SYSCLK_RATE = 100000000,
  parameter int unsigned TIMER_WIDTH = 8
) (
  input  logic                             sysClk,
  input  logic                             sysResetN,
  input  logic                             FAstrobe,
  input  logic [INDEX_WIDTH:0]             expectedCount,
  input  logic [TIMER_WIDTH-1:0]           timeoutLimit,
  input  logic [NUM_LINKS-1:0]             linkMask,
  input  logic                             completeOnEnabled,
  input  logic [NUM_LINKS-1:0]             statusValid,
  input  logic [CODE_W*NUM_LINKS-1:0]      statusCode,
  input  logic [NUM_LINKS*INDEX_WIDTH-1:0] statusIndex,
  input  logic [NUM_LINKS-1:0]             statusEnabled,
  output logic [(1<<INDEX_WIDTH)-1:0]      bitmapAll,
  output logic [(1<<INDEX_WIDTH)-1:0]      bitmapEnabled,
  output logic [(1<<INDEX_WIDTH)-1:0]      bitmapAllSnapshot,
  output logic [(1<<INDEX_WIDTH)-1:0]      bitmapEnabledSnapshot,
  output logic                             readoutActive,
  output logic                             readoutValid,
  output logic                             fmpsEnabled,
  output logic                             timeoutStrobe,
  output logic [TIMER_WIDTH-1:0]           readoutTime,
  output logic [2:0]                       seqno,
  output logic [NUM_LINKS-1:0]             linkErrorStrobe
);

  localparam int unsigned NB      = 1 << INDEX_WIDTH;
  localparam int unsigned CNT_W   = INDEX_WIDTH + 1;
  localparam int unsigned DIV_MAX = SYSCLK_RATE / 1000000 - 1;
  localparam int unsigned DIV_W   = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;

  fmps_state_e            state_q, state_d;
  logic [NB-1:0]          all_q, all_d, en_q, en_d;
  logic [NB-1:0]          all_snap_q, all_snap_d, en_snap_q, en_snap_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d, rtime_q, rtime_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic                   active_q, active_d, valid_q, valid_d;
  logic                   fmps_en_q, fmps_en_d, tstrobe_q, tstrobe_d;
  logic [2:0]             seq_q, seq_d;
  logic [NUM_LINKS-1:0]   lerr_q, lerr_d;

  logic [NB-1:0]          set_all, set_en;
  logic [CNT_W-1:0]       count_all, count_en, count_sel;
  logic                   complete, timeout_hit;
  logic [INDEX_WIDTH-1:0] idx;
  logic [CODE_W-1:0]      code;

  fmps_popcount #(.WIDTH(NB), .CNT_W(CNT_W)) u_pop_all (.data_i(all_q), .count_c(count_all));
  fmps_popcount #(.WIDTH(NB), .CNT_W(CNT_W)) u_pop_en  (.data_i(en_q),  .count_c(count_en));

  // Per-link decode: OR-merge every accepted success so coincident strobes all land.
  always_comb begin
    set_all = '0;
    set_en  = '0;
    lerr_d  = '0;
    idx     = '0;
    code    = '0;
    for (int unsigned k = 0; k < NUM_LINKS; k++) begin
      idx  = statusIndex[slice_lo(k, INDEX_WIDTH) +: INDEX_WIDTH];
      code = statusCode[slice_lo(k, CODE_W) +: CODE_W];
      lerr_d[k] = statusValid[k] && (code != ST_SUCCESS);
      if (statusValid[k] && !linkMask[k] && (code == ST_SUCCESS)) begin
        set_all[idx] = 1'b1;
        if (statusEnabled[k]) set_en[idx] = 1'b1;
      end
    end
  end

  assign count_sel   = completeOnEnabled ? count_en : count_all;
  assign complete    = (count_sel == expectedCount);
  assign timeout_hit = (timeoutLimit != '0) && (timer_q == timeoutLimit);

  // Next-state and output logic; FAstrobe overrides everything else.
  always_comb begin
    state_d    = state_q;
    all_d      = all_q;
    en_d       = en_q;
    all_snap_d = all_snap_q;
    en_snap_d  = en_snap_q;
    timer_d    = timer_q;
    div_d      = div_q;
    valid_d    = valid_q;
    fmps_en_d  = fmps_en_q;
    rtime_d    = rtime_q;
    seq_d      = seq_q;
    tstrobe_d  = 1'b0;

    if (FAstrobe) begin
      state_d    = COLLECT;
      all_snap_d = all_q;
      en_snap_d  = en_q;
      all_d      = '0;
      en_d       = '0;
      timer_d    = '0;
      valid_d    = 1'b0;
      div_d      = DIV_W'(DIV_MAX);
    end else if (state_q == COLLECT) begin
      all_d = all_q | set_all;
      en_d  = en_q | set_en;
      if (div_q == '0) begin
        div_d = DIV_W'(DIV_MAX);
        if (timer_q != {TIMER_WIDTH{1'b1}}) timer_d = timer_q + TIMER_WIDTH'(1);
      end else begin
        div_d = div_q - DIV_W'(1);
      end
      if (complete) begin
        state_d   = VALID;
        valid_d   = 1'b1;
        fmps_en_d = (count_en == expectedCount);
        rtime_d   = timer_q;
        seq_d     = seq_q + 3'd1;
      end else if (timeout_hit) begin
        state_d   = TIMEOUT;
        fmps_en_d = 1'b0;
        rtime_d   = timer_q;
        tstrobe_d = 1'b1;
      end
    end

    active_d = (state_d == COLLECT);
  end

  always_ff @(posedge sysClk or negedge sysResetN) begin
    if (!sysResetN) begin
      state_q    <= IDLE;
      all_q      <= '0;
      en_q       <= '0;
      all_snap_q <= '0;
      en_snap_q  <= '0;
      timer_q    <= '0;
      div_q      <= '0;
      active_q   <= 1'b0;
      valid_q    <= 1'b0;
      fmps_en_q  <= 1'b0;
      tstrobe_q  <= 1'b0;
      rtime_q    <= '0;
      seq_q      <= '0;
      lerr_q     <= '0;
    end else begin
      state_q    <= state_d;
      all_q      <= all_d;
      en_q       <= en_d;
      all_snap_q <= all_snap_d;
      en_snap_q  <= en_snap_d;
      timer_q    <= timer_d;
      div_q      <= div_d;
      active_q   <= active_d;
      valid_q    <= valid_d;
      fmps_en_q  <= fmps_en_d;
      tstrobe_q  <= tstrobe_d;
      rtime_q    <= rtime_d;
      seq_q      <= seq_d;
      lerr_q     <= lerr_d;
    end
  end

  assign bitmapAll             = all_q;
  assign bitmapEnabled         = en_q;
  assign bitmapAllSnapshot     = all_snap_q;
  assign bitmapEnabledSnapshot = en_snap_q;
  assign readoutActive         = active_q;
  assign readoutValid          = valid_q;
  assign fmpsEnabled           = fmps_en_q;
  assign timeoutStrobe         = tstrobe_q;
  assign readoutTime           = rtime_q;
  assign seqno                 = seq_q;
  assign linkErrorStrobe       = lerr_q;

endmodule

// File: tb/tb_fmps_gather_n.sv
// Directed bench for fmps_gather_n: completion, coincident links, masking, enabled-mode,
// timeout, FA/status collision, seqno wrap and async reset, with a result scoreboard.
module tb_fmps_gather_n;

  localparam int unsigned NL = 3;
  localparam int unsigned IW = 5;
  localparam int unsigned TW = 8;
  localparam int unsigned NB = 32;

  typedef struct packed {
    logic          is_timeout;
    logic          fmps_en;
    logic [2:0]    seq;
    logic [TW-1:0] rtime;
  } result_t;

  logic            sysClk = 1'b0;
  logic            sysResetN;
  logic            FAstrobe;
  logic [IW:0]     expectedCount;
  logic [TW-1:0]   timeoutLimit;
  logic [NL-1:0]   linkMask;
  logic            completeOnEnabled;
  logic [NL-1:0]   statusValid;
  logic [2*NL-1:0] statusCode;
  logic [NL*IW-1:0] statusIndex;
  logic [NL-1:0]   statusEnabled;
  logic [NB-1:0]   bitmapAll, bitmapEnabled, bitmapAllSnapshot, bitmapEnabledSnapshot;
  logic            readoutActive, readoutValid, fmpsEnabled, timeoutStrobe;
  logic [TW-1:0]   readoutTime;
  logic [2:0]      seqno;
  logic [NL-1:0]   linkErrorStrobe;

  int      checks = 0;
  int      failures = 0;
  int      waited;
  result_t sb[$];

  fmps_gather_n #(.NUM_LINKS(NL), .INDEX_WIDTH(IW), .SYSCLK_RATE(100000000), .TIMER_WIDTH(TW)) dut (
    .sysClk(sysClk), .sysResetN(sysResetN), .FAstrobe(FAstrobe),
    .expectedCount(expectedCount), .timeoutLimit(timeoutLimit), .linkMask(linkMask),
    .completeOnEnabled(completeOnEnabled), .statusValid(statusValid), .statusCode(statusCode),
    .statusIndex(statusIndex), .statusEnabled(statusEnabled),
    .bitmapAll(bitmapAll), .bitmapEnabled(bitmapEnabled),
    .bitmapAllSnapshot(bitmapAllSnapshot), .bitmapEnabledSnapshot(bitmapEnabledSnapshot),
    .readoutActive(readoutActive), .readoutValid(readoutValid), .fmpsEnabled(fmpsEnabled),
    .timeoutStrobe(timeoutStrobe), .readoutTime(readoutTime), .seqno(seqno),
    .linkErrorStrobe(linkErrorStrobe)
  );

  always #5 sysClk = ~sysClk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sysClk);
    #1;
  endtask

  task automatic fa();
    FAstrobe = 1'b1;
    cyc();
    FAstrobe = 1'b0;
  endtask

  task automatic strobe(input int link, input logic [IW-1:0] idx, input logic [1:0] code, input logic en);
    statusValid[link]            = 1'b1;
    statusCode[link*2 +: 2]      = code;
    statusIndex[link*IW +: IW]   = idx;
    statusEnabled[link]          = en;
    cyc();
    statusValid   = '0;
    statusCode    = '0;
    statusIndex   = '0;
    statusEnabled = '0;
  endtask

  // Wait (bounded) for a completion or timeout, then compare against the scoreboard head.
  task automatic wait_result(input string tag, input int budget, output int n);
    result_t exp;
    n = 0;
    @(negedge sysClk);
    while (!(readoutValid || timeoutStrobe) && n < budget) begin
      n++;
      @(negedge sysClk);
    end
    check({tag, "_in_budget"}, 64'(n < budget), 64'd1);
    check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      exp = sb.pop_front();
      check({tag, "_timeout"}, 64'(timeoutStrobe), 64'(exp.is_timeout));
      check({tag, "_valid"},   64'(readoutValid),  64'(!exp.is_timeout));
      check({tag, "_fmps_en"}, 64'(fmpsEnabled),   64'(exp.fmps_en));
      check({tag, "_seqno"},   64'(seqno),         64'(exp.seq));
      check({tag, "_rtime"},   64'(readoutTime),   64'(exp.rtime));
    end
  endtask

  initial begin
    sysResetN = 1'b0; FAstrobe = 1'b0; expectedCount = '0; timeoutLimit = 8'd20;
    linkMask = '0; completeOnEnabled = 1'b0;
    statusValid = '0; statusCode = '0; statusIndex = '0; statusEnabled = '0;
    repeat (3) cyc();
    sysResetN = 1'b1;
    repeat (2) cyc();
    @(negedge sysClk);
    check("rst_active", 64'(readoutActive), 64'd0);
    check("rst_valid",  64'(readoutValid),  64'd0);
    check("rst_bitmap", 64'(bitmapAll),     64'd0);
    check("rst_seqno",  64'(seqno),         64'd0);

    // Four successes complete expectedCount=4; result 2 cycles after last strobe.
    expectedCount = 7'd4;
    cyc();
    fa();
    @(negedge sysClk);
    check("t1_active", 64'(readoutActive), 64'd1);
    cyc();
    strobe(0, 5'd0, 2'd0, 1'b1);
    strobe(1, 5'd1, 2'd0, 1'b1);
    strobe(2, 5'd2, 2'd0, 1'b1);
    sb.push_back('{1'b0, 1'b1, 3'd1, 8'd0});
    strobe(0, 5'd3, 2'd0, 1'b1);
    wait_result("t1", 50, waited);
    check("t1_latency", 64'(waited), 64'd1);
    check("t1_bitmap_all", 64'(bitmapAll),     64'h0F);
    check("t1_bitmap_en",  64'(bitmapEnabled), 64'h0F);
    check("t1_active_done", 64'(readoutActive), 64'd0);

    // Three links hit index 7 together, then a masked error, then index 8.
    expectedCount = 7'd2;
    cyc();
    fa();
    @(negedge sysClk);
    check("t2_snap_all", 64'(bitmapAllSnapshot),     64'h0F);
    check("t2_snap_en",  64'(bitmapEnabledSnapshot), 64'h0F);
    check("t2_cleared",  64'(bitmapAll),             64'd0);
    check("t2_valid_clr", 64'(readoutValid),         64'd0);
    cyc();
    statusValid = 3'b111; statusIndex = {5'd7, 5'd7, 5'd7}; statusEnabled = 3'b111;
    cyc();
    statusValid = '0; statusIndex = '0; statusEnabled = '0;
    @(negedge sysClk);
    check("t2_same_idx", 64'(bitmapAll), 64'h80);
    cyc();
    linkMask = 3'b010;
    strobe(1, 5'd4, 2'd2, 1'b1);
    @(negedge sysClk);
    check("t3_err_pulse", 64'(linkErrorStrobe), 64'b010);
    check("t3_bitmap",    64'(bitmapAll),       64'h80);
    cyc();
    @(negedge sysClk);
    check("t3_err_once", 64'(linkErrorStrobe), 64'd0);
    cyc();
    strobe(1, 5'd5, 2'd0, 1'b1);
    @(negedge sysClk);
    check("t3_masked_ok", 64'(bitmapAll), 64'h80);
    cyc();
    linkMask = '0;
    sb.push_back('{1'b0, 1'b1, 3'd2, 8'd0});
    strobe(1, 5'd8, 2'd0, 1'b1);
    wait_result("t2", 50, waited);
    check("t2_latency", 64'(waited), 64'd1);
    check("t2_bitmap",  64'(bitmapAll), 64'h180);

    // Completion on enabled count only.
    completeOnEnabled = 1'b1;
    expectedCount = 7'd2;
    cyc();
    fa();
    strobe(0, 5'd0, 2'd0, 1'b0);
    strobe(1, 5'd1, 2'd0, 1'b1);
    repeat (3) cyc();
    @(negedge sysClk);
    check("t4_no_complete", 64'(readoutValid), 64'd0);
    check("t4_active",      64'(readoutActive), 64'd1);
    cyc();
    sb.push_back('{1'b0, 1'b1, 3'd3, 8'd0});
    strobe(2, 5'd2, 2'd0, 1'b1);
    wait_result("t4", 50, waited);
    check("t4_latency", 64'(waited), 64'd1);
    check("t4_bm_en",   64'(bitmapEnabled), 64'h6);
    check("t4_bm_all",  64'(bitmapAll),     64'h7);
    completeOnEnabled = 1'b0;

    // Only 3 of 5 arrive: timeout at 20 µs.
    expectedCount = 7'd5;
    cyc();
    fa();
    strobe(0, 5'd10, 2'd0, 1'b1);
    strobe(1, 5'd11, 2'd0, 1'b1);
    strobe(2, 5'd12, 2'd0, 1'b1);
    sb.push_back('{1'b1, 1'b0, 3'd3, 8'd20});
    wait_result("t5", 2200, waited);
    check("t5_timing", 64'(waited >= 1997 && waited <= 1999), 64'd1);
    check("t5_active", 64'(readoutActive), 64'd0);
    cyc();
    @(negedge sysClk);
    check("t5_strobe_once", 64'(timeoutStrobe), 64'd0);
    cyc();
    strobe(0, 5'd20, 2'd0, 1'b1);
    @(negedge sysClk);
    check("t5_outside_collect", 64'(bitmapAll), 64'h1C00);

    // expectedCount=0 completes on the first COLLECT cycle.
    expectedCount = 7'd0;
    cyc();
    sb.push_back('{1'b0, 1'b1, 3'd4, 8'd0});
    fa();
    wait_result("t6", 50, waited);
    check("t6_latency", 64'(waited), 64'd1);

    // Status coincident with FAstrobe is discarded.
    expectedCount = 7'd1;
    cyc();
    statusValid[0] = 1'b1; statusIndex[4:0] = 5'd9; statusEnabled[0] = 1'b1;
    fa();
    statusValid = '0; statusIndex = '0; statusEnabled = '0;
    @(negedge sysClk);
    check("t7_discard", 64'(bitmapAll), 64'd0);
    cyc();
    @(negedge sysClk);
    check("t7_no_valid", 64'(readoutValid), 64'd0);
    cyc();
    sb.push_back('{1'b0, 1'b1, 3'd5, 8'd0});
    strobe(0, 5'd9, 2'd0, 1'b1);
    wait_result("t7", 50, waited);

    // seqno wraps 7->0.
    expectedCount = 7'd0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      sb.push_back('{1'b0, 1'b1, 3'(6 + i), 8'd0});
      fa();
      wait_result("wrap", 50, waited);
    end

    // Async reset mid-COLLECT clears everything immediately.
    expectedCount = 7'd10;
    cyc();
    fa();
    for (int i = 0; i < 4; i++) strobe(i % 3, 5'(i), 2'd0, 1'b1);
    @(negedge sysClk);
    check("t8_pre_bitmap", 64'(bitmapAll), 64'h0F);
    #2;
    sysResetN = 1'b0;
    #1;
    check("t8_rst_active", 64'(readoutActive), 64'd0);
    check("t8_rst_bitmap", 64'(bitmapAll),     64'd0);
    check("t8_rst_snap",   64'(bitmapAllSnapshot), 64'd0);
    check("t8_rst_seqno",  64'(seqno),         64'd0);
    check("t8_rst_fmps",   64'(fmpsEnabled),   64'd0);
    cyc();
    sysResetN = 1'b1;
    cyc();
    fa();
    @(negedge sysClk);
    check("t8_snap_after", 64'(bitmapAllSnapshot), 64'd0);
    check("t8_collect",    64'(readoutActive),     64'd1);
    check("sb_drained",    64'(sb.size()),         64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fmps_gather_n.md
FMPS_GATHER_N -- requirements
Module: fmps_gather_n

Interface
REQ-001 SHALL have parameter NUM_LINKS, default 2, number of status sources (1..8).
REQ-002 SHALL have parameter INDEX_WIDTH, default 5, FMPS index width; bitmap width NB = 2^INDEX_WIDTH.
REQ-003 SHALL have parameter SYSCLK_RATE, default 100000000, sysClk frequency in Hz (multiple of 1 MHz).
REQ-004 SHALL have parameter TIMER_WIDTH, default 8, width of the µs readout timer.
REQ-005 SHALL have one clock and an asynchronous, active-low reset, with ports: sysClk in 1, system clock; sysResetN in 1, asynchronous active-low reset.
REQ-006 SHALL have input ports: FAstrobe in 1, start of FA cycle; expectedCount in INDEX_WIDTH+1, FMPS count for completion; timeoutLimit in TIMER_WIDTH, timeout in µs (0 = disabled); linkMask in NUM_LINKS, 1 = ignore link; completeOnEnabled in 1, completion mode.
REQ-007 SHALL have per-link input ports: statusValid in NUM_LINKS; statusCode in 2*NUM_LINKS; statusIndex in NUM_LINKS*INDEX_WIDTH; statusEnabled in NUM_LINKS; link k occupies slice k.
REQ-008 SHALL have bitmap output ports: bitmapAll, bitmapEnabled, bitmapAllSnapshot, bitmapEnabledSnapshot, each out NB.
REQ-009 SHALL have status output ports: readoutActive, readoutValid, fmpsEnabled, timeoutStrobe, each out 1; readoutTime out TIMER_WIDTH; seqno out 3; linkErrorStrobe out NUM_LINKS.

Function
REQ-010 SHALL implement FSM states IDLE, COLLECT, VALID, TIMEOUT; reset state is IDLE.
REQ-011 FAstrobe in any state SHALL: enter COLLECT next cycle; copy bitmaps to snapshots; clear bitmaps, timer and readoutValid; preload µs divider to SYSCLK_RATE/1e6-1.
REQ-012 In COLLECT, each link k with statusValid=1, linkMask[k]=0 and statusCode=0 SHALL set bitmapAll[index]; it SHALL also set bitmapEnabled[index] if statusEnabled=1.
REQ-013 Simultaneous updates from several links, including the same index, SHALL all be applied in one cycle as a bitwise OR; no status SHALL be dropped.
REQ-014 countAll and countEnabled SHALL be combinational popcounts of the registered bitmaps.
REQ-015 Completion SHALL occur when the selected count equals expectedCount: countEnabled if completeOnEnabled=1, else countAll.
REQ-016 On completion, the FSM SHALL move COLLECT->VALID; set readoutValid=1; latch fmpsEnabled=(countEnabled==expectedCount); latch readoutTime from the timer; increment seqno, wrapping 7->0.
REQ-017 Latency SHALL be: status strobe at cycle t, bitmap bit visible at t+1, readoutValid at t+2 when that strobe completes the set.
REQ-018 expectedCount=0 SHALL complete on the first COLLECT cycle.
REQ-019 The timer SHALL increment once per µs in COLLECT and saturate at all-ones.
REQ-020 When timeoutLimit≠0 and timer==timeoutLimit, the FSM SHALL move COLLECT->TIMEOUT; set fmpsEnabled=0; latch readoutTime; pulse timeoutStrobe for exactly one cycle; leave seqno unchanged.
REQ-021 Completion and timeout in the same cycle SHALL resolve as completion.
REQ-022 FAstrobe coincident with statusValid SHALL discard that status.
REQ-023 Statuses arriving outside COLLECT SHALL NOT change the bitmaps.
REQ-024 linkErrorStrobe[k] SHALL pulse for one cycle, registered, for every statusValid[k] with statusCode≠0, in any state, regardless of linkMask.
REQ-025 readoutActive SHALL be 1 exactly in COLLECT.
REQ-026 expectedCount, timeoutLimit, linkMask and completeOnEnabled SHALL be sampled continuously; changes mid-cycle take effect on the next clock.

Reset
REQ-027 Asserting sysResetN=0 SHALL asynchronously clear all state, including mid-COLLECT: FSM to IDLE; every output 0; bitmaps and snapshots 0; seqno 0.
REQ-028 Deassertion SHALL be synchronised externally; the block SHALL take no action until the first FAstrobe.

Structure
REQ-029 Package fmps_pkg SHALL hold the status-code constants (ST_SUCCESS=0), the FSM state encoding and the link-slice width helpers.
REQ-030 The popcount SHALL be a sub-module fmps_popcount parameterised by width and instantiated twice.

Verification (NUM_LINKS=3, INDEX_WIDTH=5, 100 MHz, timeoutLimit=20)
REQ-031 expectedCount=4; indices 0,1,2,3 success, enabled -> readoutValid 2 cycles after the last strobe; fmpsEnabled=1; seqno 0->1.
REQ-032 All three links strobe index 7 in the same cycle, then index 8 -> countAll=2 after 2 updates; expectedCount=2 completes.
REQ-033 expectedCount=5, only 3 statuses -> TIMEOUT at 20 µs ±1 cycle; one timeoutStrobe pulse; readoutTime=20; seqno unchanged.
REQ-034 linkMask=3'b010, link 1 strobes index 4 with code 2 -> bitmap unchanged; linkErrorStrobe[1] pulses once.
REQ-035 completeOnEnabled=1, expectedCount=2, indices 0,1 with enabled=0/1 -> no completion until index 2 enabled; fmpsEnabled=1.
REQ-036 sysResetN=0 mid-COLLECT with bitmapAll=0x0F -> outputs 0 immediately; next FAstrobe gives snapshot=0.
